// File: rtl/oc8051_ram_arb_if.sv
// Bundle of requester, status and RAM port-1 signals for oc8051_ram_arb.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface oc8051_ram_arb_if #(
  parameter int ADR_WIDTH = 6,
  parameter int DAT_WIDTH = 32
);
  logic                 req_a;
  logic                 we_a;
  logic [ADR_WIDTH-1:0] adr_a;
  logic [DAT_WIDTH-1:0] dat_a;
  logic                 req_b;
  logic                 we_b;
  logic [ADR_WIDTH-1:0] adr_b;
  logic [DAT_WIDTH-1:0] dat_b;
  logic                 gnt_a;
  logic                 gnt_b;
  logic                 ack_a;
  logic                 ack_b;
  logic [DAT_WIDTH-1:0] rdat;
  logic                 busy;
  logic [ADR_WIDTH-1:0] ram_adr;
  logic [DAT_WIDTH-1:0] ram_din;
  logic                 ram_en;
  logic                 ram_wr;
  logic [DAT_WIDTH-1:0] ram_dout;

  modport slave (
    input  req_a, we_a, adr_a, dat_a,
    input  req_b, we_b, adr_b, dat_b,
    output gnt_a, gnt_b, ack_a, ack_b, rdat, busy,
    output ram_adr, ram_din, ram_en, ram_wr,
    input  ram_dout
  );

  modport master (
    output req_a, we_a, adr_a, dat_a,
    output req_b, we_b, adr_b, dat_b,
    input  gnt_a, gnt_b, ack_a, ack_b, rdat, busy,
    input  ram_adr, ram_din, ram_en, ram_wr,
    output ram_dout
  );
endinterface

// File: rtl/oc8051_ram_arb.sv
// Round-robin arbiter for oc8051 internal RAM port 1 between requesters A and B.
// Define OC8051_RAM_CLR_EN to build the post-reset clear sweep (CLR state, busy).
module oc8051_ram_arb #(
  parameter int ADR_WIDTH = 6,
  parameter int DAT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  oc8051_ram_arb_if.slave     bus
);

  logic                 lastA_q, lastA_d;
  logic                 ackA_q, ackB_q;
  logic                 clrActive;
  logic                 gntA, gntB;
  logic [ADR_WIDTH-1:0] ramAdr;
  logic [DAT_WIDTH-1:0] ramDin;
  logic                 ramEn, ramWr;

`ifdef OC8051_RAM_CLR_EN
  typedef enum logic {ST_CLR, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [ADR_WIDTH-1:0] clrCnt_q, clrCnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLR;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  // The sweep leaves CLR right after the top address has been written.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    if (state_q == ST_CLR) begin
      clrCnt_d = clrCnt_q + 1'b1;
      if (clrCnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  assign clrActive = (state_q == ST_CLR);
`else
  assign clrActive = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastA_q <= 1'b0;
      ackA_q  <= 1'b0;
      ackB_q  <= 1'b0;
    end else begin
      lastA_q <= lastA_d;
      ackA_q  <= gntA;
      ackB_q  <= gntB;
    end
  end

  // Under contention the requester not served most recently wins.
  always_comb begin
    gntA    = 1'b0;
    gntB    = 1'b0;
    lastA_d = lastA_q;
    if (!clrActive) begin
      if (bus.req_a && (!bus.req_b || !lastA_q)) begin
        gntA = 1'b1;
      end else if (bus.req_b) begin
        gntB = 1'b1;
      end
    end
    if (gntA) begin
      lastA_d = 1'b1;
    end else if (gntB) begin
      lastA_d = 1'b0;
    end
  end

  always_comb begin
    ramEn  = gntA | gntB;
    ramWr  = 1'b0;
    ramAdr = bus.adr_a;
    ramDin = bus.dat_a;
    if (gntA) begin
      ramWr = bus.we_a;
    end else if (gntB) begin
      ramWr  = bus.we_b;
      ramAdr = bus.adr_b;
      ramDin = bus.dat_b;
    end
`ifdef OC8051_RAM_CLR_EN
    if (clrActive) begin
      ramEn  = 1'b1;
      ramWr  = 1'b1;
      ramAdr = clrCnt_q;
      ramDin = '0;
    end
`endif
  end

  assign bus.gnt_a   = gntA;
  assign bus.gnt_b   = gntB;
  assign bus.ack_a   = ackA_q;
  assign bus.ack_b   = ackB_q;
  assign bus.rdat    = bus.ram_dout;
  assign bus.busy    = clrActive;
  assign bus.ram_adr = ramAdr;
  assign bus.ram_din = ramDin;
  assign bus.ram_en  = ramEn;
  assign bus.ram_wr  = ramWr;

endmodule

// File: tb/tb_oc8051_ram_arb.sv
// Self-checking bench for oc8051_ram_arb: fixed vector table, hand sequences for
// reset/sweep corners, and a randomized run against a transaction-level reference.
module tb_oc8051_ram_arb;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  oc8051_ram_arb_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

  oc8051_ram_arb #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural RAM port 1: registered read, write returns the written word.
  logic [DW-1:0] ramMem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_wr) begin
        ramMem[bus.ram_adr] <= bus.ram_din;
        bus.ram_dout        <= bus.ram_din;
      end else begin
        bus.ram_dout <= ramMem[bus.ram_adr];
      end
    end
  end

  // Reference state: what each requester should see, from the arbitration rules.
  bit          refLastWasA;
  logic [31:0] refMem   [DEPTH];
  bit          refValid [DEPTH];

  typedef struct {
    bit          reqA;
    bit          weA;
    logic [5:0]  adrA;
    logic [31:0] datA;
    bit          reqB;
    bit          weB;
    logic [5:0]  adrB;
    logic [31:0] datB;
    bit          expGntA;
    bit          expGntB;
    logic [31:0] expRdat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(bit ra, bit wa, logic [5:0] aa, logic [31:0] da,
                                 bit rb, bit wb, logic [5:0] ab, logic [31:0] db,
                                 bit ga, bit gb, logic [31:0] rd);
    vec_t v;
    v.reqA = ra; v.weA = wa; v.adrA = aa; v.datA = da;
    v.reqB = rb; v.weB = wb; v.adrB = ab; v.datB = db;
    v.expGntA = ga; v.expGntB = gb; v.expRdat = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit ra, input bit wa, input logic [5:0] aa, input logic [31:0] da,
                               input bit rb, input bit wb, input logic [5:0] ab, input logic [31:0] db);
    bus.req_a = ra; bus.we_a = wa; bus.adr_a = aa; bus.dat_a = da;
    bus.req_b = rb; bus.we_b = wb; bus.adr_b = ab; bus.dat_b = db;
  endtask

  task automatic resetModel();
    refLastWasA = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = '0;
`ifdef OC8051_RAM_CLR_EN
      refValid[i] = 1'b1;
`else
      refValid[i] = 1'b0;
`endif
    end
  endtask

  // Entered just after a posedge with rst_n released; leaves just after a posedge.
  task automatic checkSweep();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checkOutput("sweepBusy", bus.busy, 1);
      checkOutput("sweepAdr", bus.ram_adr, i);
      checkOutput("sweepWrite", {bus.ram_en, bus.ram_wr, bus.gnt_a, bus.gnt_b, |bus.ram_din}, 5'b11000);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("sweepBusyFall", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rstAcks", {bus.ack_a, bus.ack_b}, 2'b00);
    checkOutput("rstGnts", {bus.gnt_a, bus.gnt_b}, 2'b00);
`ifdef OC8051_RAM_CLR_EN
    checkOutput("rstBusy", bus.busy, 1);
`else
    checkOutput("rstBusy", bus.busy, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef OC8051_RAM_CLR_EN
    checkSweep();
`endif
  endtask

  // Per-cycle ack/rdat tracking shared by the table and random phases.
  bit          prevGntA, prevGntB, prevKnown;
  logic [31:0] prevRdat;

  task automatic checkAck(input string tag);
    checkOutput({tag, "AckA"}, bus.ack_a, prevGntA);
    checkOutput({tag, "AckB"}, bus.ack_b, prevGntB);
    if ((prevGntA || prevGntB) && prevKnown) begin
      checkOutput({tag, "Rdat"}, bus.rdat, prevRdat);
    end
  endtask

  initial begin
    bit          hit;
    bit          pendA, pendB, wA, wB, mA, mB;
    logic [5:0]  aA, aB, gAdr;
    logic [31:0] dA, dB, gDat;
    bit          gWe;

    for (int i = 0; i < DEPTH; i++) ramMem[i] = $urandom;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

`ifndef OC8051_RAM_CLR_EN
    // Leaving reset with A already requesting: immediate grant.
    applyStimulus(1, 0, 6'h05, 0, 0, 0, 0, 0);
    #1;
    checkOutput("offRstBusy", bus.busy, 0);
    checkOutput("offRstAckA", bus.ack_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("offFirstGntA", bus.gnt_a, 1);
    checkOutput("offFirstEn", bus.ram_en, 1);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("offFirstAckA", bus.ack_a, 1);
    checkOutput("offFirstAckB", bus.ack_b, 0);
    @(posedge clk); #1;
`else
    #1;
    checkOutput("onRstBusy", bus.busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkSweep();
    // Reset again when the sweep reaches address 20.
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bus.busy && bus.ram_adr == 6'd20) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("sweepReach20", hit, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midSweepBusy", bus.busy, 1);
    checkOutput("midSweepAdr", bus.ram_adr, 0);
    checkOutput("midSweepAcks", {bus.ack_a, bus.ack_b}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkSweep();
    // The cleared RAM reads zero.
    applyStimulus(1, 0, 6'h2A, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clrRdGnt", bus.gnt_a, 1);
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clrRdAck", bus.ack_a, 1);
    checkOutput("clrRdData", bus.rdat, 32'h0);
    @(posedge clk); #1;
`endif

    // Fixed vectors, starting right after reset so A wins the first contention.
    tbl.push_back(mkVec(1,1,6'h10,32'hA0000001, 1,1,6'h20,32'hB0000001, 1,0,32'hA0000001));
    tbl.push_back(mkVec(1,1,6'h11,32'hA0000002, 1,1,6'h20,32'hB0000001, 0,1,32'hB0000001));
    tbl.push_back(mkVec(1,1,6'h11,32'hA0000002, 1,1,6'h21,32'hB0000002, 1,0,32'hA0000002));
    tbl.push_back(mkVec(1,1,6'h12,32'hA0000003, 1,1,6'h21,32'hB0000002, 0,1,32'hB0000002));
    tbl.push_back(mkVec(1,1,6'h12,32'hA0000003, 1,1,6'h22,32'hB0000003, 1,0,32'hA0000003));
    tbl.push_back(mkVec(1,0,6'h10,32'h0,        1,1,6'h22,32'hB0000003, 0,1,32'hB0000003));
    tbl.push_back(mkVec(1,0,6'h10,32'h0,        0,0,6'h00,32'h0,        1,0,32'hA0000001));
    tbl.push_back(mkVec(1,1,6'h05,32'hDEADBEEF, 0,0,6'h00,32'h0,        1,0,32'hDEADBEEF));
    tbl.push_back(mkVec(1,0,6'h05,32'h0,        0,0,6'h00,32'h0,        1,0,32'hDEADBEEF));
    tbl.push_back(mkVec(0,0,6'h00,32'h0,        1,1,6'h3F,32'h12345678, 0,1,32'h12345678));
    tbl.push_back(mkVec(1,0,6'h3F,32'h0,        0,0,6'h00,32'h0,        1,0,32'h12345678));
    tbl.push_back(mkVec(0,0,6'h00,32'h0,        0,0,6'h00,32'h0,        0,0,32'h0));
    tbl.push_back(mkVec(0,0,6'h00,32'h0,        1,0,6'h20,32'h0,        0,1,32'hB0000001));

    doReset();
    prevGntA = 0; prevGntB = 0; prevKnown = 0; prevRdat = '0;
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) begin
        applyStimulus(tbl[i].reqA, tbl[i].weA, tbl[i].adrA, tbl[i].datA,
                      tbl[i].reqB, tbl[i].weB, tbl[i].adrB, tbl[i].datB);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      if (i < tbl.size()) begin
        checkOutput("vecGntA", bus.gnt_a, tbl[i].expGntA);
        checkOutput("vecGntB", bus.gnt_b, tbl[i].expGntB);
        checkOutput("vecEn", bus.ram_en, tbl[i].expGntA | tbl[i].expGntB);
        if (tbl[i].expGntA) begin
          checkOutput("vecAdrA", bus.ram_adr, tbl[i].adrA);
          checkOutput("vecWrA", bus.ram_wr, tbl[i].weA);
          if (tbl[i].weA) checkOutput("vecDinA", bus.ram_din, tbl[i].datA);
        end else if (tbl[i].expGntB) begin
          checkOutput("vecAdrB", bus.ram_adr, tbl[i].adrB);
          checkOutput("vecWrB", bus.ram_wr, tbl[i].weB);
          if (tbl[i].weB) checkOutput("vecDinB", bus.ram_din, tbl[i].datB);
        end else begin
          checkOutput("vecIdleWr", bus.ram_wr, 0);
        end
      end
      checkAck("vec");
      if (i < tbl.size()) begin
        prevGntA = tbl[i].expGntA; prevGntB = tbl[i].expGntB;
        prevRdat = tbl[i].expRdat; prevKnown = 1'b1;
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of an access drops the pending ack.
    applyStimulus(1, 1, 6'h07, 32'h55AA55AA, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("midAccGnt", bus.gnt_a, 1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("midAccAckRst", bus.ack_a, 0);
    @(posedge clk); #1;
    checkOutput("midAccAckHeld", bus.ack_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midAccAckDropped", bus.ack_a, 0);
    @(posedge clk); #1;

    // Randomized requesters against the transaction-level reference.
    doReset();
    resetModel();
    prevGntA = 0; prevGntB = 0; prevKnown = 0; prevRdat = '0;
    pendA = 0; pendB = 0; wA = 0; wB = 0; aA = 0; aB = 0; dA = 0; dB = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pendA && $urandom_range(0, 1) == 1) begin
        pendA = 1; wA = $urandom_range(0, 1) == 1; aA = 6'($urandom_range(0, 15)); dA = $urandom;
      end else if (pendA && $urandom_range(0, 15) == 0) begin
        pendA = 0;
      end
      if (!pendB && $urandom_range(0, 1) == 1) begin
        pendB = 1; wB = $urandom_range(0, 1) == 1; aB = 6'($urandom_range(0, 15)); dB = $urandom;
      end else if (pendB && $urandom_range(0, 15) == 0) begin
        pendB = 0;
      end
      applyStimulus(pendA, wA, aA, dA, pendB, wB, aB, dB);

      // A lone requester is served; when both wait, the one served less recently goes.
      if (pendA && pendB) begin
        mA = !refLastWasA; mB = refLastWasA;
      end else begin
        mA = pendA; mB = pendB;
      end
      gWe  = mA ? wA : wB;
      gAdr = mA ? aA : aB;
      gDat = mA ? dA : dB;

      @(negedge clk);
      checkOutput("rndGntA", bus.gnt_a, mA);
      checkOutput("rndGntB", bus.gnt_b, mB);
      checkOutput("rndEn", bus.ram_en, mA | mB);
      if (mA || mB) begin
        checkOutput("rndAdr", bus.ram_adr, gAdr);
        checkOutput("rndWr", bus.ram_wr, gWe);
        if (gWe) checkOutput("rndDin", bus.ram_din, gDat);
      end
      checkAck("rnd");

      prevGntA = mA; prevGntB = mB;
      if (mA || mB) begin
        refLastWasA = mA;
        if (gWe) begin
          refMem[gAdr] = gDat; refValid[gAdr] = 1'b1;
          prevRdat = gDat; prevKnown = 1'b1;
        end else begin
          prevRdat = refMem[gAdr]; prevKnown = refValid[gAdr];
        end
      end
      if (mA) pendA = 0;
      if (mB) pendB = 0;
      @(posedge clk); #1;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkAck("rndLast");
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
